// File: rtl/pc_unit.sv
// Program counter / redirect stage: computes JAL, JALR and B-type targets, steers fetch, and raises flush.
// Optional taken-redirect counter (taken_cnt) is built when BRANCH_STATS_EN is defined.
module pc_unit #(
  parameter int              BITS         = 32,
  parameter logic [BITS-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [BITS-1:0] instruction,
  input  logic [BITS-1:0] ex_pc,
  input  logic [BITS-1:0] rs1,
  input  logic            branch,
  output logic [BITS-1:0] pc,
  output logic            fetch_valid,
  output logic            flush,
  output logic [BITS-1:0] link,
  output logic            misaligned
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     taken_cnt
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  state_t          state, state_nx;
  logic [BITS-1:0] pc_nx, target;
  logic [BITS-1:0] imm_j, imm_i, imm_b;
  logic [3:0]      cnt, cnt_nx;
  logic            mis_nx, taken;
  logic [6:0]      opcode;

  assign opcode = instruction[6:0];
  assign imm_j  = {{(BITS-20){instruction[31]}}, instruction[19:12], instruction[20],
                   instruction[30:21], 1'b0};
  assign imm_i  = {{(BITS-12){instruction[31]}}, instruction[31:20]};
  assign imm_b  = {{(BITS-12){instruction[31]}}, instruction[7], instruction[30:25],
                   instruction[11:8], 1'b0};
  assign link   = ex_pc + BITS'(4);

  always_comb begin
    target = ex_pc + imm_b;
    taken  = 1'b0;
    case (opcode)
      OP_JAL:  begin target = ex_pc + imm_j;                           taken = 1'b1; end
      OP_JALR: begin target = (rs1 + imm_i) & ~(BITS'(1));            taken = 1'b1; end
      OP_BR:   begin target = ex_pc + imm_b;                           taken = 1'b1; end
      default: ;
    endcase
    taken = taken & ex_valid & branch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      cnt        <= '0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      cnt        <= cnt_nx;
      misaligned <= mis_nx;
    end
  end

  // ex_* inputs are only trusted in RUN; in FLUSH they belong to the wrong path.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    cnt_nx   = cnt;
    mis_nx   = misaligned;
    case (state)
      BOOT: state_nx = RUN;
      RUN: begin
        if (taken) begin
          if (target[1:0] == 2'b00) begin
            pc_nx    = target;
            cnt_nx   = 4'(FLUSH_CYCLES - 1);
            state_nx = FLUSH;
          end else begin
            mis_nx   = 1'b1;
            state_nx = HALT;
          end
        end else if (!stall) begin
          pc_nx = pc + BITS'(4);
        end
      end
      FLUSH: begin
        if (!stall) pc_nx = pc + BITS'(4);
        if (cnt == 4'd0) state_nx = RUN;
        else             cnt_nx   = cnt - 4'd1;
      end
      HALT: ;
      default: state_nx = BOOT;
    endcase
  end

  always_comb begin
    fetch_valid = 1'b0;
    flush       = 1'b0;
    case (state)
      RUN:     fetch_valid = 1'b1;
      FLUSH:   begin fetch_valid = 1'b1; flush = 1'b1; end
      default: ;
    endcase
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      taken_cnt <= '0;
    else if (state == RUN && taken && target[1:0] == 2'b00 && taken_cnt != 32'hFFFF_FFFF)
      taken_cnt <= taken_cnt + 32'd1;
  end
`endif

endmodule
